divc_seq16: RTL and testbench



---
 rtl/divc_pkg.sv | 14 +
 rtl/divc_step.sv | 29 ++
 rtl/divc_seq16.sv | 114 +++++++++++
 tb/tb_divc_seq16.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/divc_pkg.sv
// Shared definitions for the iterative 16-bit divider: operand width, counter width
// and the sequencing state encoding.
package divc_pkg;

  localparam int DIVC_DW = 16;
  localparam int DIVC_CW = $clog2(DIVC_DW);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/divc_step.sv
// One radix-2 restoring iteration: shift {prem,qreg} left, trial-subtract the divisor,
// keep the difference and set the quotient bit when it does not borrow.
module divc_step #(
  parameter int DW = 16
) (
  input  logic [DW:0]   prem,
  input  logic [DW-1:0] qreg,
  input  logic [DW-1:0] divisor,
  output logic [DW:0]   prem_nxt,
  output logic [DW-1:0] qreg_nxt
);

  logic [DW+1:0] shifted;
  logic [DW+1:0] trial;

  always_comb begin
    shifted = {prem, qreg[DW-1]};
    trial   = shifted - {2'b00, divisor};
    // prem < divisor always holds, so shifted fits DW+1 bits and the top bit is a pure borrow
    if (!trial[DW+1]) begin
      prem_nxt = trial[DW:0];
      qreg_nxt = {qreg[DW-2:0], 1'b1};
    end else begin
      prem_nxt = shifted[DW:0];
      qreg_nxt = {qreg[DW-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/divc_seq16.sv
// Iterative signed/unsigned divider: IDLE -> CALC (DW iterations) -> FIX, results
// registered at FIX with a one-cycle done pulse; start is ignored while busy.
module divc_seq16
  import divc_pkg::*;
#(
  parameter int DW = DIVC_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          sgn,
  input  logic [DW-1:0] dvd,
  input  logic [DW-1:0] dvs,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quo,
  output logic [DW-1:0] rem,
  output logic          dz
);

  localparam int CW = $clog2(DW);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [DW:0]   prem;
  logic [DW-1:0] qreg;
  logic [DW-1:0] divisor;
  logic          qneg;
  logic          rneg;
  logic          dz_cap;

  logic [DW:0]   prem_step;
  logic [DW-1:0] qreg_step;
  logic [DW-1:0] dvd_mag;
  logic [DW-1:0] dvs_mag;
  logic [DW-1:0] rem_mag;

  divc_step #(.DW(DW)) u_step (
    .prem     (prem),
    .qreg     (qreg),
    .divisor  (divisor),
    .prem_nxt (prem_step),
    .qreg_nxt (qreg_step)
  );

  // 0x8000 negates to itself and is then treated as an unsigned magnitude
  always_comb begin
    dvd_mag = (sgn && dvd[DW-1]) ? -dvd : dvd;
    dvs_mag = (sgn && dvs[DW-1]) ? -dvs : dvs;
    rem_mag = prem[DW-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_CALC;
      ST_CALC: if (cnt == '0) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      prem    <= '0;
      qreg    <= '0;
      divisor <= '0;
      qneg    <= 1'b0;
      rneg    <= 1'b0;
      dz_cap  <= 1'b0;
      done    <= 1'b0;
      quo     <= '0;
      rem     <= '0;
      dz      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            qneg    <= sgn & (dvd[DW-1] ^ dvs[DW-1]);
            rneg    <= sgn & dvd[DW-1];
            prem    <= '0;
            qreg    <= dvd_mag;
            divisor <= dvs_mag;
            cnt     <= CW'(DW-1);
            dz_cap  <= (dvs == '0);
          end
        end
        ST_CALC: begin
          prem <= prem_step;
          qreg <= qreg_step;
          cnt  <= cnt - CW'(1);
        end
        ST_FIX: begin
          // on divide-by-zero prem holds |dvd|, so the remainder sign fix restores the raw dividend
          quo  <= dz_cap ? '1 : (qneg ? -qreg : qreg);
          rem  <= rneg ? -rem_mag : rem_mag;
          dz   <= dz_cap;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_divc_seq16.sv
// Directed and randomised checks of divc_seq16 against hand-computed values and a
// truncating-division reference.
module tb_divc_seq16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [15:0] dvd;
  logic [15:0] dvs;
  logic        busy;
  logic        done;
  logic [15:0] quo;
  logic [15:0] rem;
  logic        dz;

  int checks = 0;
  int errors = 0;

  divc_seq16 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sgn   (sgn),
    .dvd   (dvd),
    .dvs   (dvs),
    .busy  (busy),
    .done  (done),
    .quo   (quo),
    .rem   (rem),
    .dz    (dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          s;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    bit          z;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; returns at the negedge of the done cycle (or after the budget).
  task automatic do_op(input bit s, input logic [15:0] a, input logic [15:0] b, input int poke,
                       output logic [15:0] q, output logic [15:0] r, output logic z,
                       output int lat, output int bcnt);
    sgn = s; dvd = a; dvs = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; bcnt = 0; q = '0; r = '0; z = 1'b0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        lat = n; q = quo; r = rem; z = dz;
      end else if (n == poke) begin
        sgn = ~s; dvd = 16'hFFFF; dvs = 16'h0001; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
  endtask

  task automatic ref_div(input bit s, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] q, output logic [15:0] r, output logic z);
    int sa, sb;
    if (b == 16'h0) begin
      q = 16'hFFFF; r = a; z = 1'b1;
    end else if (s) begin
      sa = int'($signed(a)); sb = int'($signed(b));
      q = 16'(sa / sb); r = 16'(sa % sb); z = 1'b0;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] q, r, eq, er;
    logic        z, ez;
    int          lat, bcnt, seen;
    bit          s;
    logic [15:0] a, b;

    vecs[0] = '{1'b0, 16'h03E8, 16'h0007, 16'h008E, 16'h0006, 1'b0};
    vecs[1] = '{1'b1, 16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0};
    vecs[2] = '{1'b1, 16'h0064, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0};
    vecs[3] = '{1'b1, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1};
    vecs[4] = '{1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0};
    vecs[5] = '{1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0};
    vecs[6] = '{1'b1, 16'h8000, 16'h0000, 16'hFFFF, 16'h8000, 1'b1};
    vecs[7] = '{1'b0, 16'hFFFF, 16'h0010, 16'h0FFF, 16'h000F, 1'b0};
    vecs[8] = '{1'b1, 16'hFF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 1'b0};
    vecs[9] = '{1'b0, 16'h0005, 16'h0009, 16'h0000, 16'h0005, 1'b0};

    rst = 1'b1; start = 1'b0; sgn = 1'b0; dvd = '0; dvs = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_quo", 32'(quo), 32'h0);
    chk("rst_rem", 32'(rem), 32'h0);
    chk("rst_dz", 32'(dz), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // directed table; each operation is started in the previous one's done cycle
    foreach (vecs[i]) begin
      do_op(vecs[i].s, vecs[i].a, vecs[i].b, 0, q, r, z, lat, bcnt);
      chk($sformatf("dir%0d_lat", i), 32'(lat), 32'd18);
      chk($sformatf("dir%0d_busy", i), 32'(bcnt), 32'd17);
      chk($sformatf("dir%0d_quo", i), 32'(q), 32'(vecs[i].q));
      chk($sformatf("dir%0d_rem", i), 32'(r), 32'(vecs[i].r));
      chk($sformatf("dir%0d_dz", i), 32'(z), 32'(vecs[i].z));
    end

    // start pulsed mid-operation must be ignored
    do_op(1'b0, 16'h03E8, 16'h0007, 5, q, r, z, lat, bcnt);
    chk("poke_lat", 32'(lat), 32'd18);
    chk("poke_quo", 32'(q), 32'h008E);
    chk("poke_rem", 32'(r), 32'h0006);
    @(negedge clk);
    chk("poke_not_queued", 32'(busy), 32'h0);

    // reset part-way through CALC
    sgn = 1'b0; dvd = 16'h03E8; dvs = 16'h0007; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 8; n++) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_done", 32'(done), 32'h0);
    chk("midrst_quo", 32'(quo), 32'h0);
    chk("midrst_rem", 32'(rem), 32'h0);
    chk("midrst_dz", 32'(dz), 32'h0);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("midrst_nodone", 32'(seen), 32'h0);
    do_op(1'b0, 16'hFFFF, 16'h0010, 0, q, r, z, lat, bcnt);
    chk("postrst_lat", 32'(lat), 32'd18);
    chk("postrst_quo", 32'(q), 32'h0FFF);
    chk("postrst_rem", 32'(r), 32'h000F);

    // random operands against the reference model
    for (int k = 0; k < 300; k++) begin
      s = 1'($urandom_range(0, 1));
      a = 16'($urandom);
      b = 16'($urandom);
      case ($urandom_range(0, 9))
        0: b = 16'h0000;
        1: begin a = 16'h8000; b = 16'hFFFF; end
        2: b = 16'($urandom_range(1, 15));
        default: ;
      endcase
      ref_div(s, a, b, eq, er, ez);
      do_op(s, a, b, 0, q, r, z, lat, bcnt);
      chk($sformatf("rnd%0d_lat", k), 32'(lat), 32'd18);
      chk($sformatf("rnd%0d_quo s=%0d %h/%h", k, s, a, b), 32'(q), 32'(eq));
      chk($sformatf("rnd%0d_rem s=%0d %h/%h", k, s, a, b), 32'(r), 32'(er));
      chk($sformatf("rnd%0d_dz", k), 32'(z), 32'(ez));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
